// File: rtl/leaf_stream_packetizer_if.sv
// Bus bundle for the leaf stream packetizer: user word stream in, BFT packets in and out.
// The slave modport is the packetizer side; master is whoever drives it.
interface leaf_stream_packetizer_if #(
   parameter int unsigned PACKET_BITS  = 49,
   parameter int unsigned PAYLOAD_BITS = 32
);
   logic [PACKET_BITS-1:0]  din_leaf_bft2interface;
   logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;
   logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
   logic                    vld_user2interface;
   logic                    ack_interface2user;

   modport master (
      output din_leaf_bft2interface,
      output din_leaf_user2interface,
      output vld_user2interface,
      input  dout_leaf_interface2bft,
      input  ack_interface2user
   );

   modport slave (
      input  din_leaf_bft2interface,
      input  din_leaf_user2interface,
      input  vld_user2interface,
      output dout_leaf_interface2bft,
      output ack_interface2user
   );
endinterface

// File: rtl/leaf_stream_packetizer.sv
// Buffers user output words and wraps them into credit-metered BFT packets
// addressed to a destination leaf/port programmed by a config packet.
module leaf_stream_packetizer #(
   parameter int unsigned PACKET_BITS        = 49,
   parameter int unsigned PAYLOAD_BITS       = 32,
   parameter int unsigned NUM_LEAF_BITS      = 5,
   parameter int unsigned NUM_PORT_BITS      = 4,
   parameter int unsigned NUM_ADDR_BITS      = 7,
   parameter int unsigned NUM_BRAM_ADDR_BITS = 7,
   parameter int unsigned FIFO_DEPTH_BITS    = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   leaf_stream_packetizer_if.slave  bus,
   output logic                     configured
);

   localparam int unsigned CreditBits = NUM_BRAM_ADDR_BITS + 1;
   localparam int unsigned SumBits    = CreditBits + 1;
   localparam int unsigned CreditMax  = 1 << NUM_BRAM_ADDR_BITS;
   localparam int unsigned FifoDepth  = 1 << FIFO_DEPTH_BITS;
   localparam int unsigned PortLo     = PAYLOAD_BITS + NUM_ADDR_BITS;

   typedef enum logic [0:0] {StUnconfig, StRun} state_e;

   state_e                     state_q, state_d;
   logic [NUM_LEAF_BITS-1:0]   dest_leaf_q, dest_leaf_d;
   logic [NUM_PORT_BITS-1:0]   dest_port_q, dest_port_d;
   logic [NUM_ADDR_BITS-1:0]   addr_q, addr_d;
   logic [CreditBits-1:0]      credit_q, credit_d;
   logic [PACKET_BITS-1:0]     dout_q, dout_d;
   logic [FIFO_DEPTH_BITS:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PAYLOAD_BITS-1:0]    mem_q [FifoDepth];

   logic                       in_valid, is_credit, is_config;
   logic [NUM_PORT_BITS-1:0]   in_port;
   logic [CreditBits-1:0]      credit_n;
   logic [PAYLOAD_BITS-1:0]    in_payload;
   logic                       fifo_empty, fifo_full, push, emit;
   logic [PAYLOAD_BITS-1:0]    head;
   logic [SumBits-1:0]         credit_sum;
   logic                       unused_bft;

   assign in_valid   = bus.din_leaf_bft2interface[PACKET_BITS-1];
   assign in_port    = bus.din_leaf_bft2interface[PortLo +: NUM_PORT_BITS];
   assign in_payload = bus.din_leaf_bft2interface[PAYLOAD_BITS-1:0];
   assign credit_n   = bus.din_leaf_bft2interface[NUM_BRAM_ADDR_BITS:0];
   assign is_credit  = in_valid && (in_port == '0);
   assign is_config  = in_valid && (in_port == NUM_PORT_BITS'(1));
   assign unused_bft = ^bus.din_leaf_bft2interface;

   // Extra pointer bit distinguishes full from empty when indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_DEPTH_BITS] != rd_ptr_q[FIFO_DEPTH_BITS]) &&
                       (wr_ptr_q[FIFO_DEPTH_BITS-1:0] == rd_ptr_q[FIFO_DEPTH_BITS-1:0]);

   assign push = bus.vld_user2interface && !fifo_full && !reset;
   assign bus.ack_interface2user = push;

   // Empty FIFO bypasses the incoming word so it leaves one cycle after acceptance.
   assign head = fifo_empty ? bus.din_leaf_user2interface
                            : mem_q[rd_ptr_q[FIFO_DEPTH_BITS-1:0]];
   assign emit = (state_q == StRun) && (!fifo_empty || push) && (credit_q != '0);

   always_comb begin
      state_d     = state_q;
      dest_leaf_d = dest_leaf_q;
      dest_port_d = dest_port_q;
      addr_d      = addr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      dout_d      = '0;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (emit) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         addr_d   = addr_q + 1'b1;
         dout_d   = {1'b1, dest_leaf_q, dest_port_q, addr_q, head};
      end

      if (is_config) begin
         dest_leaf_d = in_payload[NUM_PORT_BITS +: NUM_LEAF_BITS];
         dest_port_d = in_payload[NUM_PORT_BITS-1:0];
         addr_d      = '0;
      end

      unique case (state_q)
         StUnconfig: if (is_config) state_d = StRun;
         StRun:      state_d = StRun;
         default:    state_d = StUnconfig;
      endcase

      // Never underflows: emit implies credit_q >= 1.
      credit_sum = SumBits'(credit_q) + (is_credit ? SumBits'(credit_n) : '0) - SumBits'(emit);
      if (credit_sum > SumBits'(CreditMax)) begin
         credit_d = CreditBits'(CreditMax);
      end else begin
         credit_d = credit_sum[CreditBits-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StUnconfig;
         dest_leaf_q <= '0;
         dest_port_q <= '0;
         addr_q      <= '0;
         credit_q    <= CreditBits'(CreditMax);
         dout_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         dest_leaf_q <= dest_leaf_d;
         dest_port_q <= dest_port_d;
         addr_q      <= addr_d;
         credit_q    <= credit_d;
         dout_q      <= dout_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[FIFO_DEPTH_BITS-1:0]] <= bus.din_leaf_user2interface;
      end
   end

   assign bus.dout_leaf_interface2bft = dout_q;
   assign configured                  = (state_q == StRun);

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Scoreboard bench for leaf_stream_packetizer: stimulus queues expected packets,
// a negedge monitor pops and compares every valid packet on dout.
module tb_leaf_stream_packetizer;

   logic clk = 1'b0;
   logic reset;
   logic configured;

   always #5 clk = ~clk;

   leaf_stream_packetizer_if #(.PACKET_BITS(49), .PAYLOAD_BITS(32)) bus ();

   leaf_stream_packetizer dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .configured (configured)
   );

   int checks = 0;
   int errors = 0;
   int pkt_cnt = 0;
   int base;
   int next_addr = 0;
   logic [48:0] exp_q[$];
   logic [48:0] mon_exp;
   logic [48:0] prev_pkt;
   logic [4:0]  exp_leaf = '0;
   logic [3:0]  exp_port = '0;

   function automatic logic [48:0] mk_pkt(logic [31:0] d);
      logic [6:0] a;
      a = 7'(next_addr);
      return {1'b1, exp_leaf, exp_port, a, d};
   endfunction

   function automatic logic [48:0] cfg_pkt(logic [31:0] payload);
      return {1'b1, 5'd0, 4'd1, 7'd0, payload};
   endfunction

   function automatic logic [48:0] credit_pkt(logic [31:0] n);
      return {1'b1, 5'd0, 4'd0, 7'd0, n};
   endfunction

   task automatic check(string name, logic [48:0] act, logic [48:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.dout_leaf_interface2bft[48]) begin
            pkt_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_packet: got %h expected none",
                        bus.dout_leaf_interface2bft);
            end else begin
               mon_exp = exp_q.pop_front();
               check("packet", bus.dout_leaf_interface2bft, mon_exp);
            end
         end else if (bus.dout_leaf_interface2bft !== '0) begin
            check("idle_dout", bus.dout_leaf_interface2bft, '0);
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      bus.vld_user2interface = 1'b0;
      bus.din_leaf_bft2interface = '0;
      bus.din_leaf_user2interface = '0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      next_addr = 0;
   endtask

   task automatic send_bft(logic [48:0] p);
      bus.din_leaf_bft2interface = p;
      @(posedge clk); #1;
      bus.din_leaf_bft2interface = '0;
   endtask

   // Holds vld high and waits (bounded) for ack; leaves vld asserted on return.
   task automatic push_word(logic [31:0] d);
      int t;
      bus.din_leaf_user2interface = d;
      bus.vld_user2interface = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.ack_interface2user && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!bus.ack_interface2user) begin
         errors++;
         $display("FAIL ack_timeout word %h: ack 0 expected 1", d);
      end else begin
         exp_q.push_back(mk_pkt(d));
         next_addr++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.vld_user2interface = 1'b0;
      bus.din_leaf_bft2interface = '0;
      bus.din_leaf_user2interface = '0;
      do_reset();

      // Reset state
      @(negedge clk);
      check("reset_dout", bus.dout_leaf_interface2bft, '0);
      check("reset_ack", 49'(bus.ack_interface2user), 49'd0);
      check("reset_configured", 49'(configured), 49'd0);

      // Config leaf 3 port 5, no user data
      @(posedge clk); #1;
      exp_leaf = 5'd3;
      exp_port = 4'd5;
      send_bft(cfg_pkt(32'h0000_0035));
      @(negedge clk);
      check("configured_set", 49'(configured), 49'd1);
      repeat (3) @(negedge clk);
      check("idle_after_cfg", bus.dout_leaf_interface2bft, '0);

      // Back-to-back A0..A3 with one-cycle latency
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         bus.din_leaf_user2interface = 32'hA0 + 32'(i);
         bus.vld_user2interface = 1'b1;
         @(negedge clk);
         check("ack_stream", 49'(bus.ack_interface2user), 49'd1);
         if (i > 0) check("latency", bus.dout_leaf_interface2bft, prev_pkt);
         prev_pkt = mk_pkt(32'hA0 + 32'(i));
         exp_q.push_back(prev_pkt);
         next_addr++;
         @(posedge clk); #1;
      end
      bus.vld_user2interface = 1'b0;
      @(negedge clk);
      check("latency_last", bus.dout_leaf_interface2bft, prev_pkt);
      repeat (3) @(posedge clk);
      check_int("drained_a", exp_q.size(), 0);

      // 12 words before config: 8 buffered, then backpressure
      do_reset();
      exp_leaf = 5'h1F;
      exp_port = 4'd2;
      base = pkt_cnt;
      for (int i = 0; i < 8; i++) begin
         bus.din_leaf_user2interface = 32'hB0 + 32'(i);
         bus.vld_user2interface = 1'b1;
         @(negedge clk);
         check("ack_prefill", 49'(bus.ack_interface2user), 49'd1);
         exp_q.push_back(mk_pkt(32'hB0 + 32'(i)));
         next_addr++;
         @(posedge clk); #1;
      end
      bus.din_leaf_user2interface = 32'hB8;
      @(negedge clk);
      check("ack_full", 49'(bus.ack_interface2user), 49'd0);
      check("unconfig_dout", bus.dout_leaf_interface2bft, '0);
      @(posedge clk); #1;
      send_bft(cfg_pkt(32'h0000_01F2));
      for (int i = 8; i < 12; i++) push_word(32'hB0 + 32'(i));
      bus.vld_user2interface = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check_int("prefill_count", pkt_cnt - base, 12);
      check_int("prefill_drained", exp_q.size(), 0);

      // Exhaust credit; 8 more fill the FIFO; addr wraps 127 -> 0
      do_reset();
      exp_leaf = 5'h0A;
      exp_port = 4'd7;
      send_bft(cfg_pkt(32'h0000_00A7));
      base = pkt_cnt;
      for (int i = 0; i < 136; i++) push_word(32'hC000_0000 + 32'(i));
      bus.din_leaf_user2interface = 32'hC000_0088;
      repeat (3) @(negedge clk);
      check("ack_no_credit", 49'(bus.ack_interface2user), 49'd0);
      @(posedge clk); #1;
      bus.vld_user2interface = 1'b0;
      check_int("credit_drain_count", pkt_cnt - base, 128);
      check_int("credit_drain_fifo", exp_q.size(), 8);
      send_bft(credit_pkt(32'd4));
      repeat (10) @(posedge clk);
      #1;
      check_int("credit4_count", pkt_cnt - base, 132);
      check_int("credit4_fifo", exp_q.size(), 4);

      // Reset mid-stream
      send_bft(credit_pkt(32'd3));
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      @(negedge clk);
      check("midreset_dout", bus.dout_leaf_interface2bft, '0);
      check("midreset_configured", 49'(configured), 49'd0);
      check("midreset_ack", 49'(bus.ack_interface2user), 49'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      next_addr = 0;
      send_bft(cfg_pkt(32'h0000_00A7));
      base = pkt_cnt;
      repeat (10) @(posedge clk);
      #1;
      check_int("fifo_flushed", pkt_cnt - base, 0);
      push_word(32'hDEAD_BEEF);
      bus.vld_user2interface = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_int("post_reset_word", exp_q.size(), 0);

      // Credit return of 100 at full credit, concurrent with an emission
      do_reset();
      exp_leaf = 5'd3;
      exp_port = 4'd5;
      send_bft(cfg_pkt(32'h0000_0035));
      base = pkt_cnt;
      bus.din_leaf_bft2interface = credit_pkt(32'd100);
      bus.din_leaf_user2interface = 32'hE000_0000;
      bus.vld_user2interface = 1'b1;
      @(negedge clk);
      check("ack_sat", 49'(bus.ack_interface2user), 49'd1);
      exp_q.push_back(mk_pkt(32'hE000_0000));
      next_addr++;
      @(posedge clk); #1;
      bus.din_leaf_bft2interface = '0;
      for (int i = 1; i < 137; i++) push_word(32'hE000_0000 + 32'(i));
      bus.din_leaf_user2interface = 32'hE000_0089;
      repeat (3) @(negedge clk);
      check("ack_sat_stall", 49'(bus.ack_interface2user), 49'd0);
      @(posedge clk); #1;
      bus.vld_user2interface = 1'b0;
      check_int("sat_count", pkt_cnt - base, 129);
      check_int("sat_fifo", exp_q.size(), 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
